// File: rtl/complex_div_pkg.sv
// complex_div_pkg: shared constants, types and helpers for complex_divide_seq.
//   W, FRAC      : component width and fractional bits (signed Q16.16 at defaults)
//   D            : base restoring-divide iteration count (2W+2+FRAC)
//   RND, NITER   : rounding guard-bit enable and total iteration count
//   state_t      : FSM states IDLE, MUL, SUM, DIV, DONE
//   cplx_t       : packed {re, im} operand
// Optional feature macro: COMPLEX_DIV_ROUND_EN (round half away from zero).
package complex_div_pkg;

  localparam int W    = 32;
  localparam int FRAC = 16;
  localparam int D    = 2*W + 2 + FRAC;
`ifdef COMPLEX_DIV_ROUND_EN
  localparam int RND  = 1;
`else
  localparam int RND  = 0;
`endif
  localparam int NITER = D + RND;            // quotient width, one bit per iteration
  localparam int DW    = 2*W + 1;            // numerator magnitude / denominator width
  localparam int CNT_W = $clog2(NITER + 1);

  localparam logic [W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {IDLE, MUL, SUM, DIV, DONE} state_t;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } cplx_t;

  // Sign-extend one component to product width.
  function automatic logic [2*W-1:0] sext(input logic [W-1:0] x);
    return {{W{x[W-1]}}, x};
  endfunction

  // Apply sign to an unsigned quotient magnitude and clamp to the W-bit range.
  function automatic logic [W-1:0] saturate(input logic neg, input logic [NITER-1:0] mag);
    logic [W-1:0] r;
    if (!neg) begin
      if (mag > {{(NITER-W){1'b0}}, SAT_MAX}) r = SAT_MAX;
      else                                    r = mag[W-1:0];
    end else begin
      if (mag > {{(NITER-W){1'b0}}, SAT_MIN}) r = SAT_MIN;
      else                                    r = ~mag[W-1:0] + {{(W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_div_serial.sv
// fixed_div_serial: unsigned restoring divider, one quotient bit per step.
//   load     : capture dividend, clear partial remainder
//   step     : perform one shift/compare/subtract iteration
//   dividend : NW-bit numerator, divisor : DW-bit denominator (held stable by parent)
//   quotient : NW-bit result, valid after NW steps
module fixed_div_serial #(
  parameter int NW = 82,
  parameter int DW = 65
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [NW-1:0] quotient
);

  logic [DW-1:0] rem_q, rem_d;
  logic [NW-1:0] quo_q, quo_d;
  logic [DW:0]   shifted_s;
  logic          fits_s;

  // Next-state: the partial remainder stays below divisor, so its top bit never overflows.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    shifted_s = {rem_q, quo_q[NW-1]};
    fits_s    = (shifted_s >= {1'b0, divisor});
    if (load) begin
      rem_d = {DW{1'b0}};
      quo_d = dividend;
    end else if (step) begin
      if (fits_s) begin
        rem_d = shifted_s[DW-1:0] - divisor;
        quo_d = {quo_q[NW-2:0], 1'b1};
      end else begin
        rem_d = shifted_s[DW-1:0];
        quo_d = {quo_q[NW-2:0], 1'b0};
      end
    end else begin
      rem_d = rem_q;
      quo_d = quo_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= {DW{1'b0}};
      quo_q <= {NW{1'b0}};
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/complex_divide_seq.sv
// complex_divide_seq: sequential fixed-point complex divider, result = A / B.
//   clk, rst (sync active-high), ce (clock enable; low holds all state)
//   start, A, B   : request and packed {re, im} operands, sampled on accept
//   busy, done    : busy from cycle after accept; done pulses with valid result
//   result        : packed quotient, held until the next completion
//   div_by_zero   : set with done when B == 0, cleared on next accept
// Optional feature macro: COMPLEX_DIV_ROUND_EN (guard-bit rounding, +1 cycle).
module complex_divide_seq
  import complex_div_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           start,
  input  logic [2*W-1:0] A,
  input  logic [2*W-1:0] B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           div_by_zero
);

  state_t              state_q, state_d;
  cplx_t               a_q, a_d, b_q, b_d;
  logic [2*W-1:0]      p_ac_q, p_ac_d, p_bd_q, p_bd_d, p_bc_q, p_bc_d;
  logic [2*W-1:0]      p_ad_q, p_ad_d, p_cc_q, p_cc_d, p_dd_q, p_dd_d;
  logic [DW-1:0]       den_q, den_d;
  logic                neg_r_q, neg_r_d, neg_i_q, neg_i_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [2*W-1:0]      result_q, result_d;

  logic signed [DW-1:0] nr_s, ni_s;
  logic [DW-1:0]        mag_r_s, mag_i_s, den_s;
  logic [NITER-1:0]     div_r_s, div_i_s, quo_r_s, quo_i_s, fin_r_s, fin_i_s;
  logic                 load_s, step_s;

  // Numerators/denominator from registered products; dividend is |N| << FRAC (plus guard bit).
  always_comb begin
    nr_s    = $signed({p_ac_q[2*W-1], p_ac_q}) + $signed({p_bd_q[2*W-1], p_bd_q});
    ni_s    = $signed({p_bc_q[2*W-1], p_bc_q}) - $signed({p_ad_q[2*W-1], p_ad_q});
    den_s   = {1'b0, p_cc_q} + {1'b0, p_dd_q};
    mag_r_s = nr_s[DW-1] ? (~nr_s + {{(DW-1){1'b0}}, 1'b1}) : nr_s;
    mag_i_s = ni_s[DW-1] ? (~ni_s + {{(DW-1){1'b0}}, 1'b1}) : ni_s;
    div_r_s = {{(NITER-DW){1'b0}}, mag_r_s} << (FRAC + RND);
    div_i_s = {{(NITER-DW){1'b0}}, mag_i_s} << (FRAC + RND);
  end

  fixed_div_serial #(.NW(NITER), .DW(DW)) u_div_re (
    .clk(clk), .rst(rst), .load(load_s), .step(step_s),
    .dividend(div_r_s), .divisor(den_q), .quotient(quo_r_s)
  );

  fixed_div_serial #(.NW(NITER), .DW(DW)) u_div_im (
    .clk(clk), .rst(rst), .load(load_s), .step(step_s),
    .dividend(div_i_s), .divisor(den_q), .quotient(quo_i_s)
  );

  // Final magnitude: guard bit (LSB) rounds half away from zero before saturation.
  always_comb begin
`ifdef COMPLEX_DIV_ROUND_EN
    fin_r_s = (quo_r_s >> 1) + {{(NITER-1){1'b0}}, quo_r_s[0]};
    fin_i_s = (quo_i_s >> 1) + {{(NITER-1){1'b0}}, quo_i_s[0]};
`else
    fin_r_s = quo_r_s;
    fin_i_s = quo_i_s;
`endif
  end

  // FSM next-state and datapath control; everything holds while ce is low.
  always_comb begin
    state_d  = state_q;   a_d = a_q;   b_d = b_q;
    p_ac_d   = p_ac_q;    p_bd_d = p_bd_q;  p_bc_d = p_bc_q;
    p_ad_d   = p_ad_q;    p_cc_d = p_cc_q;  p_dd_d = p_dd_q;
    den_d    = den_q;     neg_r_d = neg_r_q; neg_i_d = neg_i_q;
    cnt_d    = cnt_q;     busy_d = busy_q;  done_d = done_q;
    dbz_d    = dbz_q;     result_d = result_q;
    load_s   = 1'b0;      step_s = 1'b0;
    if (ce) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse waits one cycle.
          if (start && !done_q) begin
            a_d     = cplx_t'(A);
            b_d     = cplx_t'(B);
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
            state_d = MUL;
          end else begin
            state_d = IDLE;
          end
        end
        MUL: begin
          p_ac_d  = $signed(sext(a_q.re)) * $signed(sext(b_q.re));
          p_bd_d  = $signed(sext(a_q.im)) * $signed(sext(b_q.im));
          p_bc_d  = $signed(sext(a_q.im)) * $signed(sext(b_q.re));
          p_ad_d  = $signed(sext(a_q.re)) * $signed(sext(b_q.im));
          p_cc_d  = $signed(sext(b_q.re)) * $signed(sext(b_q.re));
          p_dd_d  = $signed(sext(b_q.im)) * $signed(sext(b_q.im));
          state_d = SUM;
        end
        SUM: begin
          den_d   = den_s;
          neg_r_d = nr_s[DW-1];
          neg_i_d = ni_s[DW-1];
          if (den_s == {DW{1'b0}}) begin
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            load_s  = 1'b1;
            cnt_d   = CNT_W'(NITER);
            state_d = DIV;
          end
        end
        DIV: begin
          step_s = 1'b1;
          cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = DONE;
          else                                    state_d = DIV;
        end
        DONE: begin
          if (dbz_q) result_d = {(2*W){1'b0}};
          else       result_d = {saturate(neg_r_q, fin_r_s), saturate(neg_i_q, fin_i_s)};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;       a_q <= '0;          b_q <= '0;
      p_ac_q  <= '0;         p_bd_q <= '0;       p_bc_q <= '0;
      p_ad_q  <= '0;         p_cc_q <= '0;       p_dd_q <= '0;
      den_q   <= '0;         neg_r_q <= 1'b0;    neg_i_q <= 1'b0;
      cnt_q   <= '0;         busy_q <= 1'b0;     done_q <= 1'b0;
      dbz_q   <= 1'b0;       result_q <= '0;
    end else begin
      state_q <= state_d;    a_q <= a_d;         b_q <= b_d;
      p_ac_q  <= p_ac_d;     p_bd_q <= p_bd_d;   p_bc_q <= p_bc_d;
      p_ad_q  <= p_ad_d;     p_cc_q <= p_cc_d;   p_dd_q <= p_dd_d;
      den_q   <= den_d;      neg_r_q <= neg_r_d; neg_i_q <= neg_i_d;
      cnt_q   <= cnt_d;      busy_q <= busy_d;   done_q <= done_d;
      dbz_q   <= dbz_d;      result_q <= result_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_complex_divide_seq.sv
// Directed self-checking bench for complex_divide_seq.
module tb_complex_divide_seq;

`ifdef COMPLEX_DIV_ROUND_EN
  localparam int          LAT    = 86;
  localparam logic [63:0] R_FRAC = 64'h0000AAAB_00000000;
`else
  localparam int          LAT    = 85;
  localparam logic [63:0] R_FRAC = 64'h0000AAAA_00000000;
`endif
  localparam logic [63:0] A1     = 64'h00040000_00020000;  // 4+2i
  localparam logic [63:0] B1     = 64'h00010000_00010000;  // 1+i
  localparam logic [63:0] R1     = 64'h00030000_FFFF0000;  // 3-i
  localparam logic [63:0] A_FRAC = 64'h00020000_00000000;  // 2
  localparam logic [63:0] B_FRAC = 64'h00030000_00000000;  // 3
  localparam logic [63:0] A_PSAT = 64'h7FFF0000_00000000;
  localparam logic [63:0] A_NSAT = 64'h80010000_00000000;  // -32767
  localparam logic [63:0] B_SAT  = 64'h00000100_00000000;  // 1/256
  localparam logic [63:0] R_PSAT = 64'h7FFFFFFF_00000000;
  localparam logic [63:0] R_NSAT = 64'h80000000_00000000;

  logic        clk = 1'b0;
  logic        rst, ce, start;
  logic [63:0] a_i, b_i;
  logic        busy, done, div_by_zero;
  logic [63:0] result;
  int          n_checks = 0;
  int          n_pass   = 0;

  complex_divide_seq dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .A(a_i), .B(b_i),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done; lat counts edges after the accept edge.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic [63:0] res, output logic dz);
    a_i = a; b_i = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    res = result;
    dz  = div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (result !== 64'h0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b expected 0", div_by_zero); else n_pass++;
  endtask

  task automatic test_basic();
    int lat; logic [63:0] res; logic dz;
    run_op(A1, B1, lat, res, dz);
    n_checks++; if (res !== R1) $display("FAIL basic_result: got %h expected %h", res, R1); else n_pass++;
    n_checks++; if (lat !== LAT) $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_checks++; if (dz !== 1'b0) $display("FAIL basic_dbz: got %b expected 0", dz); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b expected 0", busy); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", done); else n_pass++;
  endtask

  task automatic test_fraction();
    int lat; logic [63:0] res; logic dz;
    run_op(A_FRAC, B_FRAC, lat, res, dz);
    n_checks++; if (res !== R_FRAC) $display("FAIL frac_result: got %h expected %h", res, R_FRAC); else n_pass++;
    n_checks++; if (lat !== LAT) $display("FAIL frac_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    int lat; logic [63:0] res; logic dz;
    run_op(A_PSAT, B_SAT, lat, res, dz);
    n_checks++; if (res !== R_PSAT) $display("FAIL sat_pos: got %h expected %h", res, R_PSAT); else n_pass++;
    tick();
    run_op(A_NSAT, B_SAT, lat, res, dz);
    n_checks++; if (res !== R_NSAT) $display("FAIL sat_neg: got %h expected %h", res, R_NSAT); else n_pass++;
    tick();
  endtask

  task automatic test_div_by_zero();
    int lat; logic [63:0] res; logic dz;
    run_op(A1, 64'h0, lat, res, dz);
    n_checks++; if (lat !== 3) $display("FAIL dbz_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++; if (res !== 64'h0) $display("FAIL dbz_result: got %h expected 0", res); else n_pass++;
    n_checks++; if (dz !== 1'b1) $display("FAIL dbz_flag: got %b expected 1", dz); else n_pass++;
    tick();
    run_op(A1, B1, lat, res, dz);
    n_checks++; if (dz !== 1'b0) $display("FAIL dbz_cleared: got %b expected 0", dz); else n_pass++;
    tick();
  endtask

  task automatic test_busy_ignore();
    int lat; int cnt; logic [63:0] res;
    a_i = A1; b_i = B1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL busy_after_accept: got %b expected 1", busy); else n_pass++;
    cnt = 0; lat = -1; res = '0;
    for (int k = 1; k <= LAT + 30; k++) begin
      if (k == 10) begin start = 1'b1; a_i = A_FRAC; b_i = B_FRAC; end
      else start = 1'b0;
      tick();
      if (done) begin cnt++; if (lat < 0) lat = k; res = result; end
    end
    n_checks++; if (cnt !== 1) $display("FAIL busy_done_count: got %0d expected 1", cnt); else n_pass++;
    n_checks++; if (lat !== LAT) $display("FAIL busy_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_checks++; if (res !== R1) $display("FAIL busy_result: got %h expected %h", res, R1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt;
    a_i = A1; b_i = B1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (result !== 64'h0) $display("FAIL midrst_result: got %h expected 0", result); else n_pass++;
    cnt = 0;
    for (int k = 0; k < LAT + 20; k++) begin
      tick();
      if (done) cnt++;
    end
    n_checks++; if (cnt !== 0) $display("FAIL midrst_no_done: got %0d expected 0", cnt); else n_pass++;
  endtask

  task automatic test_ce_stall();
    int lat; logic [63:0] res;
    a_i = A1; b_i = B1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1; res = '0;
    for (int k = 1; k <= 300; k++) begin
      ce = (k >= 31 && k < 41) ? 1'b0 : 1'b1;
      tick();
      if (done) begin lat = k; res = result; break; end
    end
    n_checks++; if (lat !== LAT + 10) $display("FAIL ce_latency: got %0d expected %0d", lat, LAT + 10); else n_pass++;
    n_checks++; if (res !== R1) $display("FAIL ce_result: got %h expected %h", res, R1); else n_pass++;
    ce = 1'b0;
    repeat (3) tick();
    n_checks++; if (done !== 1'b1) $display("FAIL ce_done_stretch: got %b expected 1", done); else n_pass++;
    ce = 1'b1;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL ce_done_release: got %b expected 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res; logic dz;
    run_op(A1, B1, lat, res, dz);
    a_i = A_FRAC; b_i = B_FRAC; start = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_not_accepted: got %b expected 0", busy); else n_pass++;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accepted: got %b expected 1", busy); else n_pass++;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    n_checks++; if (lat !== LAT) $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_checks++; if (result !== R_FRAC) $display("FAIL b2b_result: got %h expected %h", result, R_FRAC); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fraction();
    test_saturation();
    test_div_by_zero();
    test_busy_ignore();
    test_reset_mid();
    test_ce_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
